// File: rtl/acq_readout_ctrl.sv
// Capture-and-readout sequencer: arms the acquisition block, reads the trigger-aligned window
// from the four channel RAMs and streams it out through a small skid FIFO.
module acq_readout_ctrl #(
  parameter int RAM_WIDTH  = 10,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_req,
  input  logic                 abort,
  input  logic [3:0]           chan_mask,
  input  logic [RAM_WIDTH-1:0] nsmp,
  input  logic [RAM_WIDTH-1:0] triggerpoint,
  output logic                 start_trigger,
  input  logic                 data_ready,
  input  logic [RAM_WIDTH-1:0] wraddress_triggerpoint,
  output logic                 rden,
  output logic [RAM_WIDTH-1:0] rdaddress,
  input  logic [7:0]           ram_q1,
  input  logic [7:0]           ram_q2,
  input  logic [7:0]           ram_q3,
  input  logic [7:0]           ram_q4,
  output logic [7:0]           tx_data,
  output logic [1:0]           tx_chan,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 tx_last,
  output logic                 busy,
  output logic                 done
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_WAIT_TRIG, S_READ, S_DRAIN, S_DONE} state_e;
  typedef struct packed { logic v; logic [1:0] chan; logic last; } pipe_t;
  typedef struct packed { logic [1:0] chan; logic last; logic [7:0] data; } entry_t;

  state_e               state_q, state_d;
  logic [3:0]           mask_q, mask_d;
  logic [RAM_WIDTH-1:0] nsmp_q, nsmp_d, tp_q, tp_d, base_q, base_d, idx_q, idx_d;
  logic [1:0]           chan_q, chan_d;
  pipe_t                pipe_q [RD_LATENCY];
  entry_t               fifo_q [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        cnt_q, inflight;
  logic                 issue, room, is_last, last_issue, push, pop;
  logic                 nxt_found;
  logic [1:0]           nxt_chan, first_chan;
  entry_t               head, push_entry;

  // Lowest enabled channel overall, and the next enabled channel above the current one.
  always_comb begin
    first_chan = '0;
    nxt_found  = 1'b0;
    nxt_chan   = '0;
    for (int c = 3; c >= 0; c--) begin
      if (mask_q[c]) first_chan = 2'(c);
      if (mask_q[c] && (2'(c) > chan_q)) begin
        nxt_found = 1'b1;
        nxt_chan  = 2'(c);
      end
    end
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + CW'(pipe_q[i].v);
  end

  assign room       = ({1'b0, cnt_q} + {1'b0, inflight}) < (CW+1)'(FIFO_DEPTH);
  assign is_last    = (idx_q == nsmp_q - RAM_WIDTH'(1));
  assign last_issue = is_last && !nxt_found;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    nsmp_d  = nsmp_q;
    tp_d    = tp_q;
    base_d  = base_q;
    idx_d   = idx_q;
    chan_d  = chan_q;
    issue   = 1'b0;
    unique case (state_q)
      S_IDLE: if (start_req) begin
        mask_d  = chan_mask;
        nsmp_d  = nsmp;
        tp_d    = triggerpoint;
        state_d = (chan_mask == '0 || nsmp == '0) ? S_DONE : S_ARM;
      end
      S_ARM: if (!data_ready) state_d = S_WAIT_TRIG;
      S_WAIT_TRIG: if (data_ready) begin
        base_d  = wraddress_triggerpoint - tp_q;
        chan_d  = first_chan;
        idx_d   = '0;
        state_d = S_READ;
      end
      S_READ: if (room) begin
        issue = 1'b1;
        if (is_last) begin
          idx_d = '0;
          if (nxt_found) chan_d = nxt_chan;
          else           state_d = S_DRAIN;
        end else begin
          idx_d = idx_q + RAM_WIDTH'(1);
        end
      end
      S_DRAIN: if (cnt_q == '0 && inflight == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE;
      issue   = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      nsmp_q  <= '0;
      tp_q    <= '0;
      base_q  <= '0;
      idx_q   <= '0;
      chan_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      nsmp_q  <= nsmp_d;
      tp_q    <= tp_d;
      base_q  <= base_d;
      idx_q   <= idx_d;
      chan_q  <= chan_d;
    end
  end

  // Tags travel alongside the RAM so each returning byte knows its channel and last flag.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      for (int i = 0; i < RD_LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= {issue, chan_q, issue && last_issue};
      for (int i = 1; i < RD_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign push = pipe_q[RD_LATENCY-1].v;
  assign pop  = tx_valid && tx_ready;

  always_comb begin
    push_entry.chan = pipe_q[RD_LATENCY-1].chan;
    push_entry.last = pipe_q[RD_LATENCY-1].last;
    unique case (pipe_q[RD_LATENCY-1].chan)
      2'd0:    push_entry.data = ram_q1;
      2'd1:    push_entry.data = ram_q2;
      2'd2:    push_entry.data = ram_q3;
      default: push_entry.data = ram_q4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  // NOTE: FIFO storage is not reset; the count gates every read, so stale entries are never seen.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && !pop && cnt_q == CW'(FIFO_DEPTH)));
  end

  assign head          = fifo_q[rd_ptr_q];
  assign tx_valid      = (cnt_q != '0);
  assign tx_data       = tx_valid ? head.data : '0;
  assign tx_chan       = tx_valid ? head.chan : '0;
  assign tx_last       = tx_valid && head.last;
  assign rden          = issue;
  assign rdaddress     = base_q + idx_q;
  assign start_trigger = (state_q == S_ARM) && !abort;
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
endmodule
